// File: rtl/mem_loader_if.sv
// Stream and memory-bus bundle shared by the loader and its neighbours.
// The master side is the loader; the slave side is the stream source and the RAM.
interface mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    input  in_valid, in_data, mem_rdata,
    output in_ready, mem_cmd, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_rdata,
    input  in_ready, mem_cmd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_loader.sv
// Loads RAM words from a byte stream, reads them back to verify the sum, and
// keeps the CPU in reset until the image is known to be good.
module mem_loader #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [8:0]        base_addr,
  input  logic [8:0]        word_count,
  mem_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       checksum,
  output logic              cpu_hold
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RX_LO  = 3'd1;
  localparam logic [2:0] S_RX_HI  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RD_CMD = 3'd4;
  localparam logic [2:0] S_RD_CHK = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b11;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);

  logic [2:0]       state;
  logic [8:0]       base_r;
  logic [8:0]       count_r;
  logic [8:0]       idx;
  logic [7:0]       lo_byte;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      vsum;

  logic        xfer;
  logic        last_word;
  logic        range_bad;
  logic [15:0] vsum_next;

  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

  assign bus.in_ready = (state == S_RX_LO) || (state == S_RX_HI);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign last_word    = (idx == count_r - 9'd1);
  assign range_bad    = ({1'b0, base_addr} + {1'b0, word_count}) > 10'd256;
  assign vsum_next    = add16(vsum, bus.mem_rdata);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      base_r        <= '0;
      count_r       <= '0;
      idx           <= '0;
      lo_byte       <= '0;
      cnt           <= '0;
      vsum          <= '0;
      bus.mem_cmd   <= CMD_NONE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'b00;
      checksum      <= '0;
      cpu_hold      <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            base_r   <= base_addr;
            count_r  <= word_count;
            idx      <= '0;
            cnt      <= '0;
            vsum     <= '0;
            checksum <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
            cpu_hold <= 1'b1;
            if (word_count == 9'd0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (range_bad) begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state <= S_RX_LO;
              busy  <= 1'b1;
            end
          end
        end
        // Stream receive: the idle counter only runs while a byte is awaited.
        S_RX_LO, S_RX_HI: begin
          if (xfer) begin
            cnt <= '0;
            if (state == S_RX_LO) begin
              lo_byte <= bus.in_data;
              state   <= S_RX_HI;
            end else begin
              bus.mem_wdata <= {bus.in_data, lo_byte};
              bus.mem_addr  <= base_r + idx;
              bus.mem_cmd   <= CMD_WR;
              state         <= S_WRITE;
            end
          end else if (cnt == TO_LAST) begin
            state    <= S_ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'b10;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          checksum <= add16(checksum, bus.mem_wdata);
          if (last_word) begin
            idx          <= '0;
            cnt          <= '0;
            bus.mem_cmd  <= CMD_RD;
            bus.mem_addr <= base_r;
            state        <= S_RD_CMD;
          end else begin
            idx         <= idx + 9'd1;
            bus.mem_cmd <= CMD_NONE;
            state       <= S_RX_LO;
          end
        end
        // Read-back: cnt is reused as the read-latency counter.
        S_RD_CMD: begin
          if (cnt == LAT_LAST) begin
            cnt   <= '0;
            state <= S_RD_CHK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RD_CHK: begin
          vsum <= vsum_next;
          if (last_word) begin
            idx         <= '0;
            bus.mem_cmd <= CMD_NONE;
            busy        <= 1'b0;
            if (vsum_next == checksum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'b11;
            end
          end else begin
            idx          <= idx + 9'd1;
            bus.mem_addr <= base_r + idx + 9'd1;
            state        <= S_RD_CMD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
